// File: rtl/lcd_pkg.sv
// Shared LCD definitions: panel timing defaults, FSM states and the FIFO word layout
// that both the write-side packer and the read-side unpacker depend on.
package lcd_pkg;

  localparam int H_ACTIVE_DEF = 800;
  localparam int H_SYNC_DEF   = 1;
  localparam int H_BACK_DEF   = 45;
  localparam int H_FRONT_DEF  = 210;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_SYNC_DEF   = 1;
  localparam int V_BACK_DEF   = 22;
  localparam int V_FRONT_DEF  = 22;

  localparam int WORD_W  = 16;
  localparam int COLOR_W = 10;

  // Word layout: [15] reserved, [14:10] half of G, [9:0] B (word 1) or R (word 2)
  localparam int C_MSB    = 9;
  localparam int G_HI_MSB = 14;
  localparam int G_HI_LSB = 10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN
  } lcd_state_e;

  // Per-pixel attributes carried from counter time to data-return time
  typedef struct packed {
    logic act;
    logic rd;
    logic hs;
    logic vs;
    logic fs;
  } pix_stage_t;

endpackage

// File: rtl/pixel_unpack.sv
// Splits the two 16-bit FIFO words of one pixel back into 10-bit R, G, B.
module pixel_unpack
  import lcd_pkg::*;
(
  input  logic [WORD_W-1:0]  iWord1,
  input  logic [WORD_W-1:0]  iWord2,
  output logic [COLOR_W-1:0] oR,
  output logic [COLOR_W-1:0] oG,
  output logic [COLOR_W-1:0] oB
);

  // The top bit of each word is reserved by the packer and carries nothing
  logic unusedTop;
  assign unusedTop = iWord1[WORD_W-1] ^ iWord2[WORD_W-1];

  assign oR = iWord2[C_MSB:0];
  assign oG = {iWord1[G_HI_MSB:G_HI_LSB], iWord2[G_HI_MSB:G_HI_LSB]};
  assign oB = iWord1[C_MSB:0];

endmodule

// File: rtl/lcd_frame_reader.sv
// LCD scan-out: raster counters, run/drain control and a 3-stage pipeline
// (counters -> FIFO data return -> registered panel outputs).
module lcd_frame_reader
  import lcd_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BACK   = H_BACK_DEF,
  parameter int H_FRONT  = H_FRONT_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BACK   = V_BACK_DEF,
  parameter int V_FRONT  = V_FRONT_DEF
) (
  input  logic               iClk,
  input  logic               iRst,
  input  logic               iEnable,
  input  logic               iClr_err,
  input  logic [WORD_W-1:0]  iRd1_data,
  input  logic [WORD_W-1:0]  iRd2_data,
  input  logic               iRd_empty,
  output logic               oRd_req,
  output logic [COLOR_W-1:0] oR,
  output logic [COLOR_W-1:0] oG,
  output logic [COLOR_W-1:0] oB,
  output logic               oHS,
  output logic               oVS,
  output logic               oDE,
  output logic               oFrame_start,
  output logic               oUnderflow
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  lcd_state_e state, stateNxt;
  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;
  logic hLast, vLast, running;
  logic hIn, vIn;
  pix_stage_t st0, st1;
  logic [COLOR_W-1:0] unR, unG, unB;

  assign hLast   = hcnt == HW'(H_TOTAL - 1);
  assign vLast   = vcnt == VW'(V_TOTAL - 1);
  assign running = state != ST_IDLE;

  always_ff @(posedge iClk) begin
    if (iRst) state <= ST_IDLE;
    else      state <= stateNxt;
  end

  always_comb begin
    stateNxt = state;
    unique case (state)
      ST_IDLE:  if (iEnable) stateNxt = ST_RUN;
      ST_RUN:   if (!iEnable) stateNxt = ST_DRAIN;
      ST_DRAIN: begin
        if (iEnable)             stateNxt = ST_RUN;
        else if (hLast && vLast) stateNxt = ST_IDLE;
      end
      default:  stateNxt = ST_IDLE;
    endcase
  end

  // Counters sit at the origin while idle so a restart always begins at (0,0)
  always_ff @(posedge iClk) begin
    if (iRst || !running) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (hLast) begin
      hcnt <= '0;
      vcnt <= vLast ? '0 : vcnt + VW'(1);
    end else begin
      hcnt <= hcnt + HW'(1);
    end
  end

  assign hIn = (hcnt >= HW'(H_SYNC + H_BACK)) && (hcnt <= HW'(H_SYNC + H_BACK + H_ACTIVE - 1));
  assign vIn = (vcnt >= VW'(V_SYNC + V_BACK)) && (vcnt <= VW'(V_SYNC + V_BACK + V_ACTIVE - 1));

  always_comb begin
    st0.act = running && hIn && vIn;
    st0.rd  = st0.act && !iRd_empty;
    st0.hs  = running && (hcnt < HW'(H_SYNC));
    st0.vs  = running && (vcnt < VW'(V_SYNC));
    st0.fs  = running && (hcnt == '0) && (vcnt == '0);
  end

  assign oRd_req = st0.rd;

  always_ff @(posedge iClk) begin
    if (iRst) st1 <= '0;
    else      st1 <= st0;
  end

  pixel_unpack uUnpack (
    .iWord1 (iRd1_data),
    .iWord2 (iRd2_data),
    .oR     (unR),
    .oG     (unG),
    .oB     (unB)
  );

  // A starved active pixel still drives DE, but shows black
  always_ff @(posedge iClk) begin
    if (iRst) begin
      oR           <= '0;
      oG           <= '0;
      oB           <= '0;
      oDE          <= 1'b0;
      oHS          <= 1'b1;
      oVS          <= 1'b1;
      oFrame_start <= 1'b0;
    end else begin
      oR           <= (st1.act && st1.rd) ? unR : '0;
      oG           <= (st1.act && st1.rd) ? unG : '0;
      oB           <= (st1.act && st1.rd) ? unB : '0;
      oDE          <= st1.act;
      oHS          <= !st1.hs;
      oVS          <= !st1.vs;
      oFrame_start <= st1.fs;
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst)                      oUnderflow <= 1'b0;
    else if (st1.act && !st1.rd)   oUnderflow <= 1'b1;
    else if (iClr_err)             oUnderflow <= 1'b0;
  end

endmodule

// File: tb/tb_lcd_frame_reader.sv
// Bench for lcd_frame_reader on a shrunken raster (16x9 clocks per frame):
// raster-position model checked every cycle plus directed literal checks.
module tb_lcd_frame_reader;

  localparam int HA = 8, HS = 1, HB = 3, HF = 4, HT = HA + HS + HB + HF;
  localparam int VA = 4, VS = 1, VB = 2, VF = 2, VT = VA + VS + VB + VF;
  localparam int FRAME = HT * VT;

  logic iClk = 1'b0;
  logic iRst, iEnable, iClr_err, iRd_empty;
  logic [15:0] iRd1_data, iRd2_data;
  logic oRd_req, oHS, oVS, oDE, oFrame_start, oUnderflow;
  logic [9:0] oR, oG, oB;

  always #5 iClk = ~iClk;

  lcd_frame_reader #(
    .H_ACTIVE(HA), .H_SYNC(HS), .H_BACK(HB), .H_FRONT(HF),
    .V_ACTIVE(VA), .V_SYNC(VS), .V_BACK(VB), .V_FRONT(VF)
  ) dut (
    .iClk(iClk), .iRst(iRst), .iEnable(iEnable), .iClr_err(iClr_err),
    .iRd1_data(iRd1_data), .iRd2_data(iRd2_data), .iRd_empty(iRd_empty),
    .oRd_req(oRd_req), .oR(oR), .oG(oG), .oB(oB), .oHS(oHS), .oVS(oVS),
    .oDE(oDE), .oFrame_start(oFrame_start), .oUnderflow(oUnderflow)
  );

  logic [15:0] w1Tab [8] = '{16'h7FFF, 16'h0000, 16'h8ABC, 16'h1234, 16'hFFFF, 16'h0400, 16'h5555, 16'h2AAA};
  logic [15:0] w2Tab [8] = '{16'h0000, 16'h7C01, 16'h0001, 16'hF00F, 16'h8000, 16'h0000, 16'hAAAA, 16'h03FF};

  typedef struct packed {
    bit de, hs, vs, fs, uf;
    logic [9:0] r, g, b;
  } exp_t;

  int checks = 0, failures = 0;
  int cyc = 0;

  // model state: mode 0 idle, 1 run, 2 drain; p = raster position within frame
  int mode = 0, p = 0, mRd = 0;
  bit mUf = 0;
  exp_t e1 = '0, e2 = '0;

  int rdCnt = 0;
  int reqCyc[$], hsFall[$], vsFall[$], fsCyc[$], deRise[$], pix[$];
  int blackDe = 0, hsLow = 0, hsLowMax = 0;
  bit prevHS = 1, prevVS = 1, prevDE = 0;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
    end
  endtask

  function automatic int reqsIn(int lo, int hi);
    int n = 0;
    foreach (reqCyc[i]) if (reqCyc[i] >= lo && reqCyc[i] <= hi) n++;
    return n;
  endfunction

  task automatic tick();
    exp_t s0;
    int h, v, k;
    bit expReq, req;
    @(negedge iClk);
    h = p % HT;
    v = p / HT;
    s0 = '0;
    if (mode != 0) begin
      s0.hs = (h < HS);
      s0.vs = (v < VS);
      s0.fs = (p == 0);
      s0.de = (h >= HS + HB) && (h < HS + HB + HA) && (v >= VS + VB) && (v < VS + VB + VA);
    end
    expReq = s0.de && !iRd_empty;
    s0.uf = s0.de && iRd_empty;
    if (expReq) begin
      k = mRd % 8;
      s0.r = 10'(w2Tab[k] % 1024);
      s0.g = 10'(((w1Tab[k] / 1024) % 32) * 32 + (w2Tab[k] / 1024) % 32);
      s0.b = 10'(w1Tab[k] % 1024);
      mRd++;
    end

    chk("rd_req", int'(oRd_req), int'(expReq));
    chk("hs_n", int'(oHS), int'(!e2.hs));
    chk("vs_n", int'(oVS), int'(!e2.vs));
    chk("de", int'(oDE), int'(e2.de));
    chk("frame_start", int'(oFrame_start), int'(e2.fs));
    chk("underflow", int'(oUnderflow), int'(mUf));
    chk("rgb", int'({oR, oG, oB}), int'({e2.r, e2.g, e2.b}));

    req = oRd_req;
    if (oRd_req) reqCyc.push_back(cyc);
    if (prevHS && !oHS) hsFall.push_back(cyc);
    if (prevVS && !oVS) vsFall.push_back(cyc);
    if (oDE && !prevDE) deRise.push_back(cyc);
    if (oDE) pix.push_back(int'({oR, oG, oB}));
    if (oDE && {oR, oG, oB} == 30'd0) blackDe++;
    if (oFrame_start) fsCyc.push_back(cyc);
    hsLow = oHS ? 0 : hsLow + 1;
    if (hsLow > hsLowMax) hsLowMax = hsLow;
    prevHS = oHS; prevVS = oVS; prevDE = oDE;

    if (iRst) begin
      mode = 0; p = 0; e1 = '0; e2 = '0; mUf = 0;
    end else begin
      mUf = e1.uf ? 1'b1 : (iClr_err ? 1'b0 : mUf);
      e2 = e1;
      e1 = s0;
      case (mode)
        0: if (iEnable) mode = 1;
        1: begin if (!iEnable) mode = 2; p = (p + 1) % FRAME; end
        default: begin
          if (iEnable) mode = 1;
          else if (p == FRAME - 1) mode = 0;
          p = (p + 1) % FRAME;
        end
      endcase
    end

    @(posedge iClk);
    #1;
    if (req) begin
      iRd1_data = w1Tab[rdCnt % 8];
      iRd2_data = w2Tab[rdCnt % 8];
      rdCnt++;
    end
    cyc++;
  endtask

  task automatic waitPos(int target);
    int n = 0;
    while (!(mode != 0 && p == target) && n < 600) begin tick(); n++; end
    chk("wait_pos_timeout", (mode != 0 && p == target) ? 1 : 0, 1);
  endtask

  initial begin
    int e0, r0, d0;
    iRst = 1; iEnable = 0; iClr_err = 0; iRd_empty = 0;
    iRd1_data = '0; iRd2_data = '0;
    repeat (3) tick();
    iRst = 0;
    repeat (2) tick();
    chk("rst_hs", int'(oHS), 1);
    chk("rst_vs", int'(oVS), 1);
    chk("rst_de", int'(oDE), 0);
    chk("rst_rgb", int'({oR, oG, oB}), 0);
    chk("rst_rd_req", int'(oRd_req), 0);
    chk("rst_underflow", int'(oUnderflow), 0);

    // Two full frames from a cold start
    e0 = cyc;
    iEnable = 1;
    reqCyc.delete(); hsFall.delete(); vsFall.delete(); fsCyc.delete(); deRise.delete(); pix.delete();
    hsLowMax = 0;
    repeat (2 * FRAME) tick();
    chk("first_rd_req_cycle", reqCyc.size() > 0 ? reqCyc[0] - e0 : -1, 1 + (VS + VB) * HT + HS + HB);
    chk("de_after_req", (deRise.size() > 0 && reqCyc.size() > 0) ? deRise[0] - reqCyc[0] : -1, 2);
    chk("reads_line3", reqsIn(e0 + 1 + 3 * HT, e0 + 4 * HT), HA);
    chk("reads_frame1", reqsIn(e0 + 1, e0 + FRAME), HA * VA);
    chk("reads_frame2", reqsIn(e0 + FRAME + 1, e0 + 2 * FRAME), HA * VA);
    chk("pix0", pix.size() > 0 ? pix[0] : -1, int'({10'h000, 10'h3E0, 10'h3FF}));
    chk("pix1", pix.size() > 1 ? pix[1] : -1, int'({10'h001, 10'h01F, 10'h000}));
    chk("hs_period", hsFall.size() > 1 ? hsFall[1] - hsFall[0] : -1, HT);
    chk("hs_low_width", hsLowMax, 1);
    chk("vs_period", vsFall.size() > 1 ? vsFall[1] - vsFall[0] : -1, FRAME);
    chk("frame_starts", fsCyc.size(), 2);
    chk("frame_start_lat", fsCyc.size() > 0 ? fsCyc[0] - e0 : -1, 3);
    chk("frame_start_period", fsCyc.size() > 1 ? fsCyc[1] - fsCyc[0] : -1, FRAME);

    // Starve four pixels (pixels 2..5 of line 3)
    waitPos(3 * HT + HS + HB + 2);
    r0 = cyc; blackDe = 0;
    iRd_empty = 1;
    repeat (4) tick();
    iRd_empty = 0;
    chk("no_req_when_empty", reqsIn(r0, r0 + 3), 0);
    repeat (4) tick();
    chk("black_de_pixels", blackDe, 4);
    chk("underflow_sticky", int'(oUnderflow), 1);
    iClr_err = 1; tick(); iClr_err = 0; tick();
    chk("underflow_cleared", int'(oUnderflow), 0);

    // Clear coinciding with a new underflow: set wins
    waitPos(4 * HT + HS + HB + 2);
    iRd_empty = 1; tick(); iRd_empty = 0;
    iClr_err = 1; tick(); iClr_err = 0;
    chk("set_wins", int'(oUnderflow), 1);
    iClr_err = 1; tick(); iClr_err = 0;
    chk("underflow_cleared2", int'(oUnderflow), 0);

    // Drop enable mid-frame: the frame completes, then idle
    waitPos(5 * HT + 3);
    d0 = cyc;
    iEnable = 0;
    hsFall.delete(); vsFall.delete();
    repeat (200) tick();
    chk("drain_reads", reqsIn(d0, d0 + 200), 2 * HA);
    chk("drain_hs_lines", hsFall.size(), 3);
    chk("drain_last_hs", hsFall.size() > 0 ? hsFall[hsFall.size() - 1] - d0 : -1, (FRAME - HT - (5 * HT + 3)) + 2);
    chk("drain_no_new_vs", vsFall.size(), 0);
    chk("idle_hs", int'(oHS), 1);
    chk("idle_vs", int'(oVS), 1);
    chk("idle_de", int'(oDE), 0);

    // Reset mid-frame with underflow pending, then restart
    iEnable = 1;
    waitPos(5 * HT + 5);
    iRd_empty = 1; tick(); iRd_empty = 0;
    tick();
    chk("uf_before_rst", int'(oUnderflow), 1);
    iRst = 1; tick(); iRst = 0;
    chk("mid_rst_hs", int'(oHS), 1);
    chk("mid_rst_vs", int'(oVS), 1);
    chk("mid_rst_de", int'(oDE), 0);
    chk("mid_rst_rgb", int'({oR, oG, oB}), 0);
    chk("mid_rst_fs", int'(oFrame_start), 0);
    chk("mid_rst_uf", int'(oUnderflow), 0);
    chk("mid_rst_req", int'(oRd_req), 0);
    e0 = cyc;
    fsCyc.delete();
    repeat (6) tick();
    chk("restart_fs_lat", fsCyc.size() > 0 ? fsCyc[0] - e0 : -1, 3);
    repeat (HT * 4) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
